// File: rtl/sp_ram_responder_if.sv
// sp_ram_responder_if
//   Request/response bus between a RAM initiator and sp_ram_responder.
//   Initiator -> responder : en, wr_rd (1 = write, 0 = read), addr, din, valid
//   Responder -> initiator : dout (held read data), ready, error (1-cycle pulse)
//   Modports: master = initiator side, slave = responder side.
interface sp_ram_responder_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  en;
  logic                  wr_rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic                  valid;
  logic [DATA_WIDTH-1:0] dout;
  logic                  ready;
  logic                  error;

  modport master (
    output en, wr_rd, addr, din, valid,
    input  dout, ready, error
  );

  modport slave (
    input  en, wr_rd, addr, din, valid,
    output dout, ready, error
  );
endinterface

// File: rtl/sp_ram_responder.sv
// sp_ram_responder
//   Single-port RAM answering the en/wr_rd/addr/din/valid request bus.
//   After reset an initialisation sweep zeroes all DEPTH words (ready low),
//   then requests are accepted whenever en && valid && ready at a posedge.
//   Writes complete in the accepting cycle; reads deliver dout after
//   RD_LATENCY cycles, with ready low while the read is pending.
//   Addresses >= DEPTH are illegal: no array update, dout delivered as zero,
//   and error pulses for one cycle.
// Ports
//   clk  : clock, all logic on posedge
//   rstn : asynchronous active-low reset
//   bus  : slave side of sp_ram_responder_if (en, wr_rd, addr, din, valid,
//          dout, ready, error)
module sp_ram_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 200,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  sp_ram_responder_if.slave    bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]    LAT_LOAD  = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]      ptr_q,   ptr_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] dout_q,  dout_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic accept;
  logic ptr_last;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_C);
  endfunction

  // ready_q is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept   = bus.en && bus.valid && ready_q;
  assign ptr_last = (ptr_q == LAST_IDX);

  assign bus.dout  = dout_q;
  assign bus.ready = ready_q;
  assign bus.error = error_q;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:    if (ptr_last) state_d = ST_IDLE;
      ST_IDLE:    if (accept && !bus.wr_rd) state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (cnt_q == '0) state_d = ST_IDLE;
      default:    state_d = ST_INIT;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    raddr_d   = raddr_q;
    dout_d    = dout_q;
    ready_d   = 1'b0;
    error_d   = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wdata = '0;
    unique case (state_q)
      ST_INIT: begin
        mem_we   = 1'b1;
        mem_widx = ptr_q;
        ptr_d    = ptr_last ? '0 : ptr_q + IDX_W'(1);
        // ready rises on the edge that performs the last clear write.
        ready_d  = ptr_last;
      end
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          if (bus.wr_rd) begin
            if (in_range(bus.addr)) begin
              mem_we    = 1'b1;
              mem_widx  = bus.addr[IDX_W-1:0];
              mem_wdata = bus.din;
            end else begin
              error_d = 1'b1;
            end
          end else begin
            raddr_d = bus.addr;
            cnt_d   = LAT_LOAD;
            ready_d = 1'b0;
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          dout_d  = in_range(raddr_q) ? mem[raddr_q[IDX_W-1:0]] : '0;
          error_d = !in_range(raddr_q);
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  // Datapath / output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      raddr_q <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  // Storage array: cleared by the INIT sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

endmodule

// File: doc/sp_ram_responder.md
Name: sp_ram_responder

Overview:
- Synthesizable single-port RAM that answers the en/wr_rd/addr/din/valid request bus and returns dout/ready/error.
- It is the DUT side of the RAM verification environment; the UVM driver is the initiator.
- After reset it runs an initialisation sweep that zeroes the whole array.
- Reads complete after a programmable latency. Out-of-range addresses are flagged on error.

Parameters:
- ADDR_WIDTH, 8, address bus width.
- DATA_WIDTH, 32, data bus width.
- DEPTH, 200, number of implemented words. Must satisfy DEPTH <= 2**ADDR_WIDTH; addresses >= DEPTH are illegal.
- RD_LATENCY, 2, cycles from read acceptance to data delivery. Legal range 1..8.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- rstn, input, 1: asynchronous, active-low reset.
- en, input, 1: request enable.
- wr_rd, input, 1: 1 = write, 0 = read.
- addr, input, ADDR_WIDTH: word address.
- din, input, DATA_WIDTH: write data.
- valid, input, 1: request valid.
- dout, output, DATA_WIDTH: read data, registered and held.
- ready, output, 1: responder can accept a request this cycle.
- error, output, 1: one-cycle pulse marking an illegal-address access.

Behaviour:
- Reset (rstn low, asynchronous): state=INIT, init pointer=0, ready=0, dout=0, error=0, latency counter=0.
  - Array contents are not reset directly; the INIT sweep clears them.
- States:
  - INIT: writes 0 to mem[ptr] each cycle and increments ptr. ready=0. After the write to DEPTH-1, go to IDLE and drive ready=1 from the next cycle. INIT therefore lasts exactly DEPTH cycles after rstn deasserts.
  - IDLE: ready=1.
    - A request is accepted at a posedge where en && valid && ready are all high.
    - Without en, or without valid, there is no effect.
  - RD_WAIT: ready=0. Counter counts RD_LATENCY-1 down to 0, then returns to IDLE.
- Write accepted at edge T:
  - If addr < DEPTH: mem[addr] <= din at T, error=0.
  - Else: no array update; error=1 for the single cycle after T.
  - State stays IDLE and ready stays 1, so back-to-back writes proceed one per cycle.
- Read accepted at edge T:
  - Latch addr. ready <= 0 at T. Enter RD_WAIT.
  - At edge T+RD_LATENCY: dout <= mem[addr_q], or all-zero if addr_q >= DEPTH. error <= (addr_q >= DEPTH) for one cycle. ready <= 1. Return to IDLE.
  - With RD_LATENCY=1, ready is low for exactly one cycle.
- Read timing and holding:
  - Back-to-back read throughput is one read per RD_LATENCY+1 cycles.
  - dout holds its value until the next read delivery; writes never change dout.
- Read-after-write to the same address is accepted one cycle later and returns the new data; there is no hazard.
- Requests presented while ready=0 (INIT or RD_WAIT) are ignored, not queued. The initiator must hold them until ready is seen high.
- din and wr_rd are don't-care when en=0 or valid=0.
- Address bounds: address DEPTH-1 is legal and DEPTH is illegal. Addresses never wrap.
- Reset mid-read: the pending read is discarded with no delivery and no error. After rstn releases, a full INIT sweep runs again and all data is lost.
- error is never asserted during INIT and never asserted for two consecutive cycles from a single request.

Test Plan:
- Release reset. ready must stay 0 for exactly 200 cycles, then go 1. Read addr 0x05: dout=0x00000000 two cycles after acceptance, error=0.
- Write 0xDEADBEEF to 0x10, next cycle read 0x10 -> ready low for 2 cycles, then dout=0xDEADBEEF and ready=1 on the same edge. Write 0x1/0x2/0x3 back-to-back to 0x00..0x02: all three accepted in 3 consecutive cycles.
- Write to addr 0xC8 (200) -> error pulses one cycle, array unchanged (read 0xC7 still 0). Read 0xFF -> dout=0, error=1 one cycle at delivery. Read 0xC7 -> error=0.
- Hold valid=1, en=1 during RD_WAIT with a second read to 0x11 -> request accepted only when ready returns. Exactly two deliveries, second dout=mem[0x11]. Apply valid=1, en=0 -> no acceptance, dout unchanged.
- Assert rstn=0 one cycle after a read is accepted -> ready=0, dout=0, error=0 immediately, with no delivery afterwards. Then the INIT sweep runs and a read of 0x10 returns 0.
- With RD_LATENCY=1 and DEPTH=256: read 0xFF is legal (error=0), ready is low exactly one cycle, and INIT lasts 256 cycles.
